// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing constants and helpers for the VGA
// timing generator and the downstream colour-bar pattern stage.
`default_nettype none

package vga_timing_pkg;

  localparam int COUNT_W   = 10;
  localparam int COUNT_MAX = 1 << COUNT_W;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    REGION_DISPLAY = 2'd0,
    REGION_FRONT   = 2'd1,
    REGION_SYNC    = 2'd2,
    REGION_BACK    = 2'd3
  } axis_region_e;

  function automatic int axis_total(input int d, input int f, input int s, input int b);
    return d + f + s + b;
  endfunction

  function automatic int h_total(input int d, input int f, input int s, input int b);
    return axis_total(d, f, s, b);
  endfunction

  function automatic int v_total(input int d, input int f, input int s, input int b);
    return axis_total(d, f, s, b);
  endfunction

  // Regions are laid out display -> front porch -> sync -> back porch.
  function automatic axis_region_e axis_region(input logic [COUNT_W-1:0] pos,
                                               input int d, input int f, input int s);
    int p;
    p = int'(pos);
    if (p < d)              return REGION_DISPLAY;
    else if (p < d + f)     return REGION_FRONT;
    else if (p < d + f + s) return REGION_SYNC;
    else                    return REGION_BACK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical) position counter
// with wrap strobe and blank/sync decodes of the next position.
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = DEF_H_DISPLAY,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_step,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_wrap,
  output logic               o_blank_next,
  output logic               o_sync_next
);

  localparam int                 c_total = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [COUNT_W-1:0] c_last  = COUNT_W'(c_total - 1);

  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_next;
  logic               w_at_last;
  axis_region_e       w_region_next;

  assign w_at_last = (r_count == c_last);
  assign o_wrap    = i_step & w_at_last;

  always_comb begin
    w_next = r_count;
    if (i_step) begin
      w_next = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  assign w_region_next = axis_region(w_next, DISPLAY, FRONT, SYNC);
  assign o_blank_next  = (w_region_next != REGION_DISPLAY);
  assign o_sync_next   = (w_region_next == REGION_SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator producing sync, blanking,
// pixel coordinates, line/frame pulses and a frame counter.
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY   = DEF_H_DISPLAY,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_DISPLAY   = DEF_V_DISPLAY,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = SYNC_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic [COUNT_W-1:0] hpos,
  output logic [COUNT_W-1:0] vpos,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_count
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > COUNT_MAX || V_TOTAL > COUNT_MAX) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds counter range");
  end

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_h_blank_nxt;
  logic w_v_blank_nxt;
  logic w_h_sync_nxt;
  logic w_v_sync_nxt;

  logic       r_display_on;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_step       (ena),
    .o_count      (hpos),
    .o_wrap       (w_h_wrap),
    .o_blank_next (w_h_blank_nxt),
    .o_sync_next  (w_h_sync_nxt)
  );

  // The vertical axis advances only on a horizontal wrap, which already
  // includes ena, so vsync and vpos move together with hpos returning to 0.
  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_step       (w_h_wrap),
    .o_count      (vpos),
    .o_wrap       (w_v_wrap),
    .o_blank_next (w_v_blank_nxt),
    .o_sync_next  (w_v_sync_nxt)
  );

  // Flags are decoded from next-state positions so each flop lands in the
  // same cycle as the counter value it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display_on  <= 1'b1;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_display_on  <= ~w_h_blank_nxt & ~w_v_blank_nxt;
      r_hsync       <= w_h_sync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync       <= w_v_sync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      if (w_v_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign display_on  = r_display_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

`default_nettype wire
